// File: rtl/pool_relu_2x2.sv
// pool_relu_2x2: streaming 2x2 max-pool with optional ReLU over a raster feature map
module pool_relu_2x2 #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int RELU   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic signed [7:0] in_data,
  output logic              out_valid,
  output logic signed [7:0] out_data,
  output logic [15:0]       out_addr,
  output logic              done
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int LW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic signed [7:0] r_hold;
  logic signed [7:0] r_line [WIDTH/2];
  logic              w_acc, w_fire, w_last;
  logic [LW-1:0]     w_lidx;
  logic signed [7:0] w_m1, w_m2, w_res;
  logic [15:0]       w_addr;
  assign w_acc  = enable && in_valid && (r_state != DONE);
  assign w_lidx = LW'(r_col >> 1);
  assign w_m1   = (in_data > r_hold) ? in_data : r_hold;
  assign w_m2   = (r_line[w_lidx] > w_m1) ? r_line[w_lidx] : w_m1;
  assign w_res  = (RELU != 0 && w_m2 < 0) ? 8'sd0 : w_m2;
  assign w_fire = w_acc && r_row[0] && r_col[0];
  assign w_last = w_fire && r_row == RW'(HEIGHT - 1) && r_col == CW'(WIDTH - 1);
  assign w_addr = 16'(int'(r_row >> 1) * (WIDTH / 2) + int'(r_col >> 1));
  assign done   = (r_state == DONE);
  // next state: enable low always returns to IDLE; last pooled output ends the frame
  always_comb begin
    w_next = r_state;
    if (!enable) w_next = IDLE;
    else if (r_state == IDLE) w_next = RUN;
    else if (r_state == RUN && w_last) w_next = DONE;
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // counters, horizontal hold and pooled output registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_col     <= '0;
      r_row     <= '0;
      r_hold    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (!enable) begin
      r_col     <= '0;
      r_row     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
    end else begin
      out_valid <= w_fire;
      if (w_fire) begin
        out_data <= w_res;
        out_addr <= w_addr;
      end
      if (w_acc) begin
        if (!r_col[0]) r_hold <= in_data;
        r_col <= (r_col == CW'(WIDTH - 1)) ? '0 : r_col + CW'(1);
        if (r_col == CW'(WIDTH - 1)) r_row <= (r_row == RW'(HEIGHT - 1)) ? '0 : r_row + RW'(1);
      end
    end
  // line buffer keeps the top-row pair maxima; always written before being read
  always_ff @(posedge clk)
    if (w_acc && !r_row[0] && r_col[0]) r_line[w_lidx] <= w_m1;
endmodule

// File: tb/tb_pool_relu_2x2.sv
// tb_pool_relu_2x2: directed self-checking bench for pool_relu_2x2
module tb_pool_relu_2x2;
  logic clk = 1'b0, reset = 1'b1, en4 = 1'b0, en2 = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic v4, v2a, v2b, dn4, dn2a, dn2b;
  logic [7:0] d4, d2a, d2b;
  logic [15:0] a4, a2a, a2b;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  pool_relu_2x2 #(.WIDTH(4), .HEIGHT(4), .RELU(1)) u4 (
    .clk(clk), .reset(reset), .enable(en4), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v4), .out_data(d4), .out_addr(a4), .done(dn4));
  pool_relu_2x2 #(.WIDTH(2), .HEIGHT(2), .RELU(1)) u2a (
    .clk(clk), .reset(reset), .enable(en2), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v2a), .out_data(d2a), .out_addr(a2a), .done(dn2a));
  pool_relu_2x2 #(.WIDTH(2), .HEIGHT(2), .RELU(0)) u2b (
    .clk(clk), .reset(reset), .enable(en2), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v2b), .out_data(d2b), .out_addr(a2b), .done(dn2b));

  task automatic px(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // feeds 1..last into the 4x4 instance; windows complete at pixels 6, 8, 14, 16
  task automatic feed4(input int gapmax, input int last);
    int k = 0;
    for (int i = 1; i <= last; i++) begin
      logic exp_v;
      int gap;
      px(8'(i));
      exp_v = (i == 6 || i == 8 || i == 14 || i == 16);
      n_vec++;
      if (v4 !== exp_v || dn4 !== (i == 16)) begin
        n_err++;
        $display("FAIL pix%0d valid/done got %b/%b exp %b/%b", i, v4, dn4, exp_v, i == 16);
      end
      if (exp_v) begin
        n_vec++;
        if (d4 !== 8'(i) || a4 !== 16'(k)) begin
          n_err++;
          $display("FAIL pix%0d data/addr got %0d/%0d exp %0d/%0d", i, d4, a4, i, k);
        end
        k++;
      end
      gap = $urandom_range(gapmax, 0);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        n_vec++;
        if (v4 !== 1'b0) begin
          n_err++;
          $display("FAIL gap after pix%0d valid got %b exp 0", i, v4);
        end
      end
    end
  endtask

  task automatic check_clear(input string name);
    n_vec++;
    if (v4 !== 1'b0 || a4 !== 16'd0 || dn4 !== 1'b0) begin
      n_err++;
      $display("FAIL %s valid/addr/done got %b/%0d/%b exp 0/0/0", name, v4, a4, dn4);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_vec++;
    if (v4 !== 1'b0 || d4 !== 8'd0 || a4 !== 16'd0 || dn4 !== 1'b0 || v2a !== 1'b0 || dn2b !== 1'b0) begin
      n_err++;
      $display("FAIL reset outputs got v=%b d=%0d a=%0d done=%b exp all 0", v4, d4, a4, dn4);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame;
    en4 = 1'b1;
    feed4(0, 16);
  endtask

  task automatic test_post_done;
    for (int i = 0; i < 4; i++) begin
      px(8'd100);
      n_vec++;
      if (v4 !== 1'b0 || dn4 !== 1'b1 || a4 !== 16'd3 || d4 !== 8'd16) begin
        n_err++;
        $display("FAIL post_done%0d valid/done/addr/data got %b/%b/%0d/%0d exp 0/1/3/16", i, v4, dn4, a4, d4);
      end
    end
    en4 = 1'b0;
    @(negedge clk);
    check_clear("done_clear");
  endtask

  task automatic test_gaps;
    en4 = 1'b1;
    feed4(3, 16);
    en4 = 1'b0;
    @(negedge clk);
    check_clear("gaps_clear");
  endtask

  task automatic test_abort;
    en4 = 1'b1;
    feed4(0, 9);
    en4 = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd10;
    @(negedge clk);
    in_valid = 1'b0;
    check_clear("abort_clear");
    en4 = 1'b1;
    feed4(0, 16);
    en4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    en4 = 1'b1;
    feed4(0, 7);
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (v4 !== 1'b0 || d4 !== 8'd0 || a4 !== 16'd0 || dn4 !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got v=%b d=%0d a=%0d done=%b exp all 0", v4, d4, a4, dn4);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    feed4(0, 16);
    en4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_2x2;
    en2 = 1'b1;
    repeat (4) px(8'h80);
    n_vec++;
    if (v2a !== 1'b1 || d2a !== 8'h00 || a2a !== 16'd0 || dn2a !== 1'b1) begin
      n_err++;
      $display("FAIL min_relu got v=%b d=%h a=%0d done=%b exp 1/00/0/1", v2a, d2a, a2a, dn2a);
    end
    n_vec++;
    if (v2b !== 1'b1 || d2b !== 8'h80 || a2b !== 16'd0 || dn2b !== 1'b1) begin
      n_err++;
      $display("FAIL min_pass got v=%b d=%h a=%0d done=%b exp 1/80/0/1", v2b, d2b, a2b, dn2b);
    end
    en2 = 1'b0;
    @(negedge clk);
    en2 = 1'b1;
    px(8'hFF);
    px(8'hFB);
    px(8'hFD);
    px(8'h80);
    n_vec++;
    if (v2b !== 1'b1 || d2b !== 8'hFF) begin
      n_err++;
      $display("FAIL neg_pass got v=%b d=%h exp 1/ff", v2b, d2b);
    end
    n_vec++;
    if (v2a !== 1'b1 || d2a !== 8'h00) begin
      n_err++;
      $display("FAIL neg_relu got v=%b d=%h exp 1/00", v2a, d2a);
    end
    en2 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_frame;
    test_post_done;
    test_gaps;
    test_abort;
    test_async_reset;
    test_2x2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pool_relu_2x2.md
POOL_RELU_2X2 -- requirements
Module: pool_relu_2x2

Interface
REQ-001 Parameter WIDTH, default 32: input feature-map columns; SHALL be even and at least 2.
REQ-002 Parameter HEIGHT, default 32: input feature-map rows; SHALL be even and at least 2.
REQ-003 Parameter RELU, default 1: 1 clamps negative pooled results to 0, 0 passes them unchanged.
REQ-004 The ports SHALL be, in order:
- clk, input, 1: the single clock; all logic on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: high = frame in progress; low = block idle and cleared.
- in_valid, input, 1: in_data is a valid conv-stage output this cycle (CONV2D dataready).
- in_data, input, 8: signed two's-complement conv result, raster order, row-major.
- out_valid, output, 1: one-cycle pulse; out_data and out_addr valid.
- out_data, output, 8: signed pooled (and optionally rectified) value.
- out_addr, output, 16: index of the pooled value, 0 to WIDTH*HEIGHT/4-1, raster order.
- done, output, 1: sticky frame-complete flag.

Function
REQ-005 The block SHALL track column (0 to WIDTH-1) and row (0 to HEIGHT-1) counters that advance only on cycles with enable=1, in_valid=1 and done=0.
- The column counter wraps to 0 after WIDTH-1 and the row counter then increments.
REQ-006 In every row, on an even column, the block SHALL capture in_data into a hold register.
REQ-007 On an even row and odd column c, the block SHALL write the signed max(hold, in_data) into line-buffer entry c>>1.
- The line buffer has WIDTH/2 entries of 8 bits.
REQ-008 On an odd row and odd column c, the block SHALL compute the signed max of line-buffer entry c>>1, hold and in_data.
- If RELU=1, it SHALL replace a negative result with 0.
- It SHALL register the result to out_data with out_valid=1 on the next rising edge, giving a latency of 1 cycle from the accepted bottom-right pixel.
REQ-009 out_addr SHALL equal (row>>1)*(WIDTH/2)+(c>>1) for the emitted value.
- It SHALL increment by exactly 1 per out_valid pulse within a frame.
REQ-010 All comparisons SHALL be 8-bit signed with no saturation or widening; equal operands yield the same value.
REQ-011 out_valid SHALL be low in every cycle not defined by REQ-008; out_data and out_addr SHALL hold their last value when out_valid is low.
REQ-012 Gaps in in_valid of any length SHALL stall all counters and registers without loss of data.
REQ-013 The state machine SHALL have three states: IDLE (enable=0), RUN, DONE.
- IDLE to RUN: enable=1.
- RUN to DONE: on the edge that emits out_addr=WIDTH*HEIGHT/4-1; done rises together with that out_valid.
- DONE to IDLE: enable=0.
REQ-014 In DONE, done SHALL stay high and further in_valid pulses SHALL be ignored, with no out_valid and no counter change.
REQ-015 enable=0 in any state SHALL, on the next edge, clear the counters, out_addr and done, force out_valid low, and discard any partial frame.
REQ-016 When enable=0 and in_valid=1 arrive in the same cycle, enable SHALL take priority and the pixel SHALL be dropped.

Reset
REQ-017 While reset is high, the block SHALL asynchronously force out_valid=0, out_data=0, out_addr=0, done=0, counters=0, hold=0 and the state to IDLE.
- Line-buffer contents need not be reset, because every entry is written before it is read.
REQ-018 Reset asserted mid-frame SHALL abandon the frame.
- After deassertion, the first accepted pixel SHALL be treated as row 0, column 0.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- WIDTH=HEIGHT=4, RELU=1, in_data 1..16 on consecutive cycles -> out_data 6, 8, 14, 16 at out_addr 0..3, each one cycle after pixels 6, 8, 14 and 16; done high with the 4th pulse.
- WIDTH=HEIGHT=2, all inputs 0x80 (-128): RELU=1 -> out_data 0x00; RELU=0 -> 0x80. Inputs {-1, -5, -3, -128} with RELU=0 -> 0xFF.
- The 4x4 frame from scenario 1 with a random 0-3-cycle in_valid gap between pixels -> identical outputs and addresses.
- 4x4 frame, enable dropped after pixel 9, then a new frame 1..16 -> no output from the partial frame; the new frame gives 6, 8, 14, 16 at out_addr 0..3.
- reset pulsed asynchronously between clock edges mid-frame -> all outputs 0 immediately; the next frame is processed correctly from out_addr 0.
- 4 extra in_valid pulses after done -> no out_valid; done stays high until enable=0, then clears next edge.
